// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding,
// requester count and a one-hot to index helper.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Single-bit 4:1 multiplexer, select {s1,s0}.
module mux4 (
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic s0,
  input  logic s1,
  output logic y
);

  always_comb begin
    case ({s1, s0})
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating priority search: first requester with req & mask set,
// scanning from i_start upward and wrapping 3->0.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [1:0]         i_start,
  output logic               o_found,
  output logic [1:0]         o_idx
);

  always_comb begin
    logic [1:0] w_pos;
    w_pos   = '0;
    o_found = 1'b0;
    o_idx   = '0;
    // Scan from the farthest offset down so the nearest candidate wins last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = i_start + 2'(k);
      if (i_req[w_pos] && i_mask[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 word mux between four requesters, with a
// per-grant burst limit and a valid/ready output stream.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic [CNT_W-1:0]   beat_cnt
);

  logic               r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [1:0]         r_sel;
  logic [1:0]         r_last;
  logic [CNT_W-1:0]   r_beat_cnt;

  logic               w_state_next;
  logic [NUM_REQ-1:0] w_gnt_next;
  logic [1:0]         w_sel_next;
  logic [1:0]         w_last_next;
  logic [CNT_W-1:0]   w_cnt_next;

  logic               w_valid;
  logic               w_xfer;
  logic               w_release;
  logic [NUM_REQ-1:0] w_mask;
  logic [1:0]         w_start;
  logic               w_found;
  logic [1:0]         w_idx;
  logic [WIDTH-1:0]   w_mux_data;

  assign w_valid   = (r_gnt != '0) && req[r_sel];
  assign w_xfer    = w_valid && out_ready;
  assign w_release = (r_state == GRANT) &&
                     (!req[r_sel] || (w_xfer && r_beat_cnt == CNT_W'(MAX_BURST - 1)));

  // While granted the current owner is excluded so it cannot regain back-to-back.
  assign w_mask  = (r_state == GRANT) ? ~r_gnt : '1;
  assign w_start = ((r_state == GRANT) ? onehot_to_idx(r_gnt) : r_last) + 2'd1;

  rr_pick4 u_pick (
    .i_req   (req),
    .i_mask  (w_mask),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_last     <= 2'd3;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_gnt      <= w_gnt_next;
      r_sel      <= w_sel_next;
      r_last     <= w_last_next;
      r_beat_cnt <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_next = GRANT;
      default: if (w_release && !w_found) w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_next  = r_gnt;
    w_sel_next  = r_sel;
    w_last_next = r_last;
    w_cnt_next  = r_beat_cnt;
    if ((r_state == IDLE) || w_release) begin
      w_cnt_next = '0;
      if (w_found) begin
        w_gnt_next  = NUM_REQ'(1) << w_idx;
        w_sel_next  = w_idx;
        w_last_next = w_idx;
      end else begin
        w_gnt_next = '0;
      end
    end else if (w_xfer) begin
      w_cnt_next = r_beat_cnt + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
    mux4 u_mux (
      .d0 (in0[gi]),
      .d1 (in1[gi]),
      .d2 (in2[gi]),
      .d3 (in3[gi]),
      .s0 (r_sel[0]),
      .s1 (r_sel[1]),
      .y  (w_mux_data[gi])
    );
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign beat_cnt  = r_beat_cnt;
  assign out_valid = w_valid;
  assign out_data  = (r_gnt != '0) ? w_mux_data : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a driver issues per-cycle stimulus and
// queues the reference model's expected outputs; a monitor pops and compares.
module tb_mux4_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic             out_ready;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [3:0]       beat_cnt;

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [3:0]       cnt;
    logic             valid;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: owner index (-1 when idle), last winner, beats so far.
  int         m_owner;
  int         m_last;
  int         m_beats;
  logic [1:0] m_sel;

  function automatic int search(input logic [3:0] r, input int start, input int excl);
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (start + k) % 4;
      if (r[p] && p != excl) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_beats = 0;
    m_sel   = 2'd0;
  endtask

  task automatic model_take(input int w);
    if (w >= 0) begin
      m_owner = w;
      m_last  = w;
      m_sel   = 2'(w);
    end else begin
      m_owner = -1;
    end
    m_beats = 0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Drive one cycle at a falling edge, queue its expected outputs, advance model.
  task automatic cycle(input logic [3:0] r, input logic rdy);
    logic [WIDTH-1:0] d[4];
    exp_t e;
    for (int i = 0; i < 4; i++) d[i] = WIDTH'($urandom);
    req = r; out_ready = rdy;
    in0 = d[0]; in1 = d[1]; in2 = d[2]; in3 = d[3];
    e.gnt   = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e.sel   = m_sel;
    e.cnt   = 4'(m_beats);
    e.valid = (m_owner >= 0) && r[m_owner];
    e.data  = (m_owner < 0) ? '0 : d[m_owner];
    exp_q.push_back(e);
    if (m_owner < 0) begin
      model_take(search(r, (m_last + 1) % 4, -1));
    end else if (!r[m_owner]) begin
      model_take(search(r, (m_owner + 1) % 4, m_owner));
    end else if (rdy) begin
      m_beats++;
      if (m_beats == MAX_BURST) model_take(search(r, (m_owner + 1) % 4, m_owner));
    end
    @(negedge clk);
  endtask

  // Monitor: compares live outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        n_checks++;
        if (gnt === e.gnt && sel === e.sel && beat_cnt === e.cnt &&
            out_valid === e.valid && out_data === e.data) begin
          n_pass++;
        end else begin
          $display("FAIL cycle%0d: got gnt=%b sel=%0d cnt=%0d valid=%b data=%h expected gnt=%b sel=%0d cnt=%0d valid=%b data=%h",
                   cyc, gnt, sel, beat_cnt, out_valid, out_data,
                   e.gnt, e.sel, e.cnt, e.valid, e.data);
        end
      end
    end
  end

  task automatic mid_reset();
    #4;
    check("pre_reset_granted", 32'(gnt != 4'b0000), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_cnt", 32'(beat_cnt), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rr;
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("reset_gnt", 32'(gnt), 32'd0);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_sel", 32'(sel), 32'd0);
    end
    rst_n = 1'b1;

    repeat (22) cycle(4'b1111, 1'b1);                 // rotation 0,1,2,3,0
    repeat (2) cycle(4'b0000, 1'b1);
    repeat (11) cycle(4'b0100, 1'b0);                 // backpressure on 2
    repeat (4) cycle(4'b0100, 1'b1);
    repeat (2) cycle(4'b0000, 1'b1);
    repeat (12) cycle(4'b0001, 1'b1);                 // sole requester limit
    repeat (2) cycle(4'b0000, 1'b1);
    repeat (3) cycle(4'b0001, 1'b1);                  // into a burst, then reset
    mid_reset();
    repeat (3) cycle(4'b0110, 1'b1);                  // owner 1, two beats
    cycle(4'b0100, 1'b1);                             // owner withdraws
    repeat (2) cycle(4'b0100, 1'b1);
    repeat (4) cycle(4'b1000, 1'b1);

    rr = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) rr = 4'($urandom);
      cycle(rr, $urandom_range(0, 3) != 0);
    end

    #5;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
